// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request channel, decode
// handshake with the split instruction fields, and the PC redirect input.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        dec_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  func7;
  logic [4:0]  rs2;
  logic [4:0]  rs1;
  logic [2:0]  func3;
  logic [4:0]  rd;
  logic [6:0]  opcode;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
           func7, rs2, rs1, func3, rd, opcode,
    input  imem_ready, imem_rdata, dec_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
           func7, rs2, rs1, func3, rd, opcode,
    output imem_ready, imem_rdata, dec_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Single-issue instruction fetch: holds the PC, requests words from
// instruction memory and presents one decoded-field instruction at a time.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        req;
  logic        valid;

  // Redirect wins over every state; a coincident memory response or decode
  // acceptance is dropped so the stream restarts cleanly at the new target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
      ir_pc <= '0;
      req   <= 1'b0;
      valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      state <= FETCH;
      pc    <= bus.redirect_pc & ~32'h3;
      req   <= 1'b1;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          req   <= 1'b1;
        end
        FETCH: begin
          if (bus.imem_ready) begin
            ir    <= bus.imem_rdata;
            ir_pc <= pc;
            pc    <= pc + 32'(PC_STEP);
            state <= HOLD;
            req   <= 1'b0;
            valid <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.dec_ready) begin
            state <= FETCH;
            req   <= 1'b1;
            valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  // Address is forced to zero outside a request so nothing undefined leaks out.
  assign bus.imem_req    = req;
  assign bus.imem_addr   = req ? pc : 32'h0;
  assign bus.instr_valid = valid;
  assign bus.instr       = ir;
  assign bus.instr_pc    = ir_pc;
  assign bus.func7       = ir[31:25];
  assign bus.rs2         = ir[24:20];
  assign bus.rs1         = ir[19:15];
  assign bus.func3       = ir[14:12];
  assign bus.rd          = ir[11:7];
  assign bus.opcode      = ir[6:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a transaction-level PC/memory model feeds
// an expected-instruction queue that an independent monitor drains.
module tb_instr_fetch;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   idle_run;
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  logic        prev_valid;
  logic [31:0] last_instr;
  logic [31:0] last_pc;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: a fixed add at address 0, hashed words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0020_81B3;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model for the coming
  // edge, then check the request channel at the following negedge.
  task automatic apply_stimulus(input logic rdy, input logic dr, input logic rv, input logic [31:0] rpc);
    logic req_seen;
    req_seen = bus.imem_req;
    bus.imem_ready     = rdy;
    bus.imem_rdata     = req_seen ? mem_word(bus.imem_addr) : 32'(int'($urandom));
    bus.dec_ready      = dr;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (rv) begin
      model_pc = rpc & ~32'h3;
    end else if (req_seen && rdy) begin
      exp_q.push_back({mem_word(model_pc), model_pc});
      model_pc = model_pc + 32'd4;
    end
    @(negedge clk);
    if (bus.imem_req) check_output("fetch_addr", bus.imem_addr, model_pc);
    else              check_output("idle_addr_zero", bus.imem_addr, 32'h0);
    if (rv) begin
      check_output("redirect_req", 32'(bus.imem_req), 32'd1);
      check_output("redirect_drops_valid", 32'(bus.instr_valid), 32'd0);
    end
    if (bus.instr_valid && bus.imem_req) check_output("req_during_hold", 32'd1, 32'd0);
    idle_run = (!bus.imem_req && !bus.instr_valid) ? idle_run + 1 : 0;
    if (idle_run > 1) check_output("stall_watchdog", idle_run, 32'd1);
  endtask

  // Monitor: each newly presented instruction is popped and compared; a held
  // instruction must stay bit-stable while it remains valid.
  always @(negedge clk) begin
    logic [63:0] e;
    logic [31:0] w;
    if (bus.instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_instr", bus.instr, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        w = e[63:32];
        check_output("instr", bus.instr, w);
        check_output("instr_pc", bus.instr_pc, e[31:0]);
        check_output("func7", 32'(bus.func7), 32'(w[31:25]));
        check_output("rs2", 32'(bus.rs2), 32'(w[24:20]));
        check_output("rs1", 32'(bus.rs1), 32'(w[19:15]));
        check_output("func3", 32'(bus.func3), 32'(w[14:12]));
        check_output("rd", 32'(bus.rd), 32'(w[11:7]));
        check_output("opcode", 32'(bus.opcode), 32'(w[6:0]));
      end
    end else if (bus.instr_valid && prev_valid) begin
      check_output("hold_instr_stable", bus.instr, last_instr);
      check_output("hold_pc_stable", bus.instr_pc, last_pc);
    end
    prev_valid = bus.instr_valid;
    last_instr = bus.instr;
    last_pc    = bus.instr_pc;
  end

  task automatic check_all_zero();
    check_output("rst_req", 32'(bus.imem_req), 32'd0);
    check_output("rst_addr", bus.imem_addr, 32'd0);
    check_output("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_output("rst_instr", bus.instr, 32'd0);
    check_output("rst_instr_pc", bus.instr_pc, 32'd0);
    check_output("rst_fields", {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] saved;
    checks = 0; failures = 0; idle_run = 0;
    prev_valid = 1'b0; last_instr = '0; last_pc = '0;
    model_pc = 32'h0;
    rst_n = 1'b0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.dec_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    repeat (3) @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;
    #1 check_output("dead_cycle_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check_output("first_req", 32'(bus.imem_req), 32'd1);
    check_output("first_addr", bus.imem_addr, 32'h0);

    // Zero-wait fetch of the add at 0x0, then the next request at 0x4.
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    check_output("add_opcode", 32'(bus.opcode), 32'h33);
    check_output("add_rd", 32'(bus.rd), 32'd3);
    check_output("add_rs1_rs2", {bus.rs1, bus.rs2}, {22'd0, 5'd1, 5'd2});
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("next_addr", bus.imem_addr, 32'h4);

    // Wait states, then decode backpressure.
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, '0);
    check_output("wait_valid_low", 32'(bus.instr_valid), 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    repeat (4) apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    check_output("bp_valid", 32'(bus.instr_valid), 32'd1);
    check_output("bp_instr_pc", bus.instr_pc, 32'h4);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("after_bp_addr", bus.imem_addr, 32'h8);

    // Redirect while holding with decode ready.
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    check_output("redir_hold_addr", bus.imem_addr, 32'h100);

    // Redirect in FETCH coincident with ready: IR untouched.
    saved = bus.instr;
    apply_stimulus(1'b1, 1'b0, 1'b1, 32'h0000_0200);
    check_output("redir_fetch_ir", bus.instr, saved);
    check_output("redir_fetch_addr", bus.imem_addr, 32'h200);

    // PC wrap at the top of the address space.
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    check_output("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
    apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("wrap_addr", bus.imem_addr, 32'h0);

    // Reset pulse in the middle of a hold.
    apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    check_output("pre_reset_valid", 32'(bus.instr_valid), 32'd1);
    rst_n = 1'b0;
    #1 check_all_zero();
    exp_q.delete();
    model_pc = 32'h0;
    idle_run = 0;
    bus.imem_ready = 1'b0; bus.dec_ready = 1'b0; bus.redirect_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("restart_req", 32'(bus.imem_req), 32'd1);
    check_output("restart_addr", bus.imem_addr, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic rv;
      rv = ($urandom_range(0, 15) == 0);
      apply_stimulus($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                     rv, rv ? 32'(int'($urandom)) : 32'h0);
    end

    // Drain: consume whatever is held, stop issuing responses.
    repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Single-issue instruction fetch stage directly upstream of control_unit.
- Holds the PC and issues word requests to instruction memory over a req/ready handshake.
- Latches each returned instruction into an instruction register (IR) and splits it into func7/func3/opcode for control_unit, and rs1/rs2/rd for the register file.
- Presents one instruction at a time with a valid/ready handshake; supports PC redirect from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, PC increment per accepted fetch, in bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc while imem_req=1, else 0.
- imem_ready  input  1  memory returns imem_rdata this cycle; meaningful only while imem_req=1.
- imem_rdata  input  32  instruction word.
- instr_valid  output  1  IR holds an instruction for decode.
- dec_ready  input  1  decode consumes the instruction this cycle.
- instr  output  32  raw IR contents.
- instr_pc  output  32  address of the instruction in IR.
- func7  output  7  instr[31:25].
- rs2  output  5  instr[24:20].
- rs1  output  5  instr[19:15].
- func3  output  3  instr[14:12].
- rd  output  5  instr[11:7].
- opcode  output  7  instr[6:0].
- redirect_valid  input  1  load a new PC (branch/jump).
- redirect_pc  input  32  new PC; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, IR=0, instr_pc=0, state=IDLE.
  - imem_req=0, imem_addr=0, instr_valid=0, all field outputs 0.
- Field outputs are pure slices of IR; they change only when IR loads.
- FSM states:
  - IDLE: outputs idle. Next cycle -> FETCH unconditionally (exactly one dead cycle after reset release).
  - FETCH: imem_req=1, imem_addr=pc, instr_valid=0. Holds imem_req and imem_addr stable until imem_ready=1. On imem_ready=1: IR<=imem_rdata, instr_pc<=pc, pc<=pc+PC_STEP, -> HOLD.
  - HOLD: instr_valid=1, imem_req=0. IR is stable while dec_ready=0. On dec_ready=1 -> FETCH.
- Timing:
  - Instruction visible the cycle after imem_ready.
  - Minimum 2 cycles per instruction with zero-wait memory.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- redirect_valid=1 overrides everything, in any state except reset:
  - pc<=redirect_pc & ~3, next state=FETCH.
  - HOLD: the held instruction is discarded; instr_valid=0 next cycle, even if dec_ready=1 in the same cycle. IR and instr_pc keep their old values but are invalid.
  - FETCH: a simultaneous imem_ready is ignored (IR not loaded, pc not incremented). Next cycle requests redirect_pc.
  - IDLE: redirect is taken; next state FETCH at redirect_pc.
- imem_ready while imem_req=0 is ignored.
- Reset asserted mid-transaction: immediate return to reset values; any in-flight memory response is dropped.
- No X propagation: imem_addr is driven 0 whenever imem_req=0.

Test Plan:
- Reset then zero-wait memory returning 32'h0020_81B3 (add x3,x1,x2) at 0x0:
  - imem_req rises 1 cycle after rst_n release.
  - instr_valid next cycle with opcode=7'b0110011, func3=0, func7=0, rs1=1, rs2=2, rd=3, instr_pc=0.
  - Next request at 0x4.
- Memory wait states: imem_ready low for 3 cycles → imem_addr stays 0x0 and imem_req stays 1 throughout; IR loads only on the ready cycle.
- Decode backpressure: dec_ready=0 for 4 cycles in HOLD → instr_valid stays 1, fields unchanged, imem_req=0. dec_ready pulse → FETCH at pc+4.
- Redirect with redirect_pc=0x0000_0103 while in HOLD and dec_ready=1 → instr_valid=0 next cycle; next imem_addr=0x100.
- Redirect in FETCH coincident with imem_ready → IR unchanged; next imem_addr = redirect target.
- PC wrap: redirect to 0xFFFF_FFFC, fetch completes → next imem_addr=0x0.
- Mid-HOLD rst_n pulse → all outputs 0 immediately; fetch restarts at RESET_PC.
